// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Grants persist across multi-transaction sequences; a watchdog reclaims idle grants.
module spi_bus_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      wrt_in,
    input  logic [16*NUM_REQ-1:0]   wt_data_in,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done_out,
    output logic [15:0]             rd_data_out,
    output logic                    spi_wrt,
    output logic [15:0]             spi_wt_data,
    input  logic                    spi_done,
    input  logic [15:0]             spi_rd_data,
    input  logic                    spi_SS_n,
    output logic [NUM_REQ-1:0]      SS_n_out,
    output logic                    tmo_err
);

    localparam int unsigned OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW       = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam int unsigned TMO_LAST = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;

    typedef enum logic [1:0] {IDLE, GRANTED, BUSY} state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_q, last_d;
    logic [NUM_REQ-1:0]  gnt_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tmo_d;
    logic [OW-1:0]       pick;
    logic [15:0]         slice [NUM_REQ];

    // First requester above last_owner, wrapping around.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [OW-1:0] last);
        int unsigned idx;
        logic        found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(last) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && r[OW'(idx)]) begin
                found   = 1'b1;
                rr_pick = OW'(idx);
            end
        end
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = wt_data_in[16*i +: 16];
    end

    assign pick        = rr_pick(req, last_q);
    assign spi_wt_data = (|gnt) ? slice[owner_q] : 16'h0000;
    assign rd_data_out = spi_rd_data;
    assign SS_n_out    = ~gnt | {NUM_REQ{spi_SS_n}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            gnt     <= '0;
            cnt_q   <= '0;
            tmo_err <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt     <= gnt_d;
            cnt_q   <= cnt_d;
            tmo_err <= tmo_d;
        end
    end

    // Watchdog count survives only while staying in GRANTED.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        gnt_d    = gnt;
        cnt_d    = '0;
        tmo_d    = 1'b0;
        spi_wrt  = 1'b0;
        done_out = '0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    owner_d     = pick;
                    gnt_d[pick] = 1'b1;
                    state_d     = GRANTED;
                end
            end
            GRANTED: begin
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (wrt_in[owner_q]) begin
                    spi_wrt = 1'b1;
                    state_d = BUSY;
                end else if ((TMO_CYC != 0) && (cnt_q == CW'(TMO_LAST))) begin
                    tmo_d   = 1'b1;
                    gnt_d   = '0;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (spi_done) begin
                    done_out[owner_q] = 1'b1;
                    if (req[owner_q]) begin
                        state_d = GRANTED;
                    end else begin
                        gnt_d   = '0;
                        last_d  = owner_q;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: stimulus queues expected grant/strobe/done/timeout
// events with their cycle; a negedge monitor pops and compares each observed event.
module tb_spi_bus_arbiter;

    localparam int K_GNT  = 0;
    localparam int K_WRT  = 1;
    localparam int K_DONE = 2;
    localparam int K_TMO  = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          at;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, wrt_in, gnt, done_out, SS_n_out;
    logic [31:0] wt_data_in;
    logic [15:0] rd_data_out, spi_wt_data, spi_rd_data;
    logic        spi_wrt, spi_done, spi_SS_n, tmo_err;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    ev_t  q[$];
    logic [1:0] prev_gnt = 2'b00;

    spi_bus_arbiter #(.NUM_REQ(2), .TMO_CYC(8)) dut (
        .clk(clk), .rst(rst), .req(req), .wrt_in(wrt_in), .wt_data_in(wt_data_in),
        .gnt(gnt), .done_out(done_out), .rd_data_out(rd_data_out),
        .spi_wrt(spi_wrt), .spi_wt_data(spi_wt_data), .spi_done(spi_done),
        .spi_rd_data(spi_rd_data), .spi_SS_n(spi_SS_n), .SS_n_out(SS_n_out),
        .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ev(input int kind, input logic [31:0] val, input int dc);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = cyc + dc;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic see(input int kind, input logic [31:0] val);
        ev_t e;
        n_chk++;
        if (q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d val=%h cycle=%0d, want no event",
                     kind, val, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind == kind && e.val === val && e.at == cyc) n_pass++;
            else $display("FAIL event: got kind=%0d val=%h cycle=%0d, want kind=%0d val=%h cycle=%0d",
                          kind, val, cyc, e.kind, e.val, e.at);
        end
    endtask

    // Monitor: every observable DUT event is matched against the scoreboard queue.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_gnt = gnt;
        end else begin
            if (gnt !== prev_gnt) see(K_GNT, 32'(gnt));
            prev_gnt = gnt;
            if (spi_wrt !== 1'b0) see(K_WRT, 32'(spi_wt_data));
            if (done_out !== 2'b00) see(K_DONE, 32'({done_out, rd_data_out}));
            if (tmo_err !== 1'b0) see(K_TMO, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish within bound");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 2'b00; wrt_in = 2'b00; wt_data_in = 32'h0;
        spi_done = 1'b0; spi_rd_data = 16'h0; spi_SS_n = 1'b1;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ss_n", 32'(SS_n_out), 32'h3);
        chk("rst_tmo", 32'(tmo_err), 32'h0);
        chk("rst_spi_wrt", 32'(spi_wrt), 32'h0);
        chk("rst_done", 32'(done_out), 32'h0);
        chk("rst_wt_data", 32'(spi_wt_data), 32'h0);
        rst = 1'b0;

        tick();                                   // t0: contention, requester 0 first
        req = 2'b11; exp_ev(K_GNT, 32'h1, 1);
        tick();                                   // t0+1: first transaction
        wt_data_in = {16'h1111, 16'h2000}; wrt_in = 2'b01; exp_ev(K_WRT, 32'h2000, 0);
        tick();                                   // t0+2: BUSY
        wrt_in = 2'b00; spi_SS_n = 1'b0;
        #1 chk("ss_busy_owner0", 32'(SS_n_out), 32'h2);
        tick();                                   // t0+3
        spi_done = 1'b1; spi_rd_data = 16'h0ABC; exp_ev(K_DONE, 32'h0001_0ABC, 0);
        tick();                                   // t0+4: second transaction, grant held
        spi_done = 1'b0; spi_SS_n = 1'b1; wt_data_in[15:0] = 16'h0000; wrt_in = 2'b01;
        exp_ev(K_WRT, 32'h0000, 0);
        tick();                                   // t0+5
        wrt_in = 2'b00; spi_done = 1'b1; exp_ev(K_DONE, 32'h0001_0ABC, 0);
        tick();                                   // t0+6: non-owner write ignored
        spi_done = 1'b0; wrt_in = 2'b10;
        tick();                                   // t0+7: owner 0 releases, 1 waiting
        wrt_in = 2'b00; req = 2'b10;
        exp_ev(K_GNT, 32'h0, 1); exp_ev(K_GNT, 32'h2, 2);
        tick();                                   // t0+8
        tick();                                   // t0+9: owner 1
        spi_SS_n = 1'b0;
        #1 chk("ss_owner1", 32'(SS_n_out), 32'h1);
        spi_SS_n = 1'b1;
        tick();                                   // t0+10
        req = 2'b01; exp_ev(K_GNT, 32'h0, 1);
        tick();                                   // t0+11: rotation back to 0
        req = 2'b11; exp_ev(K_GNT, 32'h1, 1);
        tick();                                   // t0+12
        wt_data_in[15:0] = 16'h3456; wrt_in = 2'b01; exp_ev(K_WRT, 32'h3456, 0);
        tick();                                   // t0+13: drop req during BUSY
        wrt_in = 2'b00; req = 2'b00;
        tick();                                   // t0+14
        tick();                                   // t0+15
        spi_done = 1'b1; spi_rd_data = 16'h5A5A;
        exp_ev(K_DONE, 32'h0001_5A5A, 0); exp_ev(K_GNT, 32'h0, 1);
        tick();                                   // t0+16
        spi_done = 1'b0; req = 2'b01; exp_ev(K_GNT, 32'h1, 1);
        tick();                                   // t0+17: release and write together
        req = 2'b00; wrt_in = 2'b01; exp_ev(K_GNT, 32'h0, 1);
        tick();                                   // t0+18
        wrt_in = 2'b00; req = 2'b10; exp_ev(K_GNT, 32'h2, 1);
        tick();                                   // t0+19
        req = 2'b00; exp_ev(K_GNT, 32'h0, 1);
        tick();                                   // t0+20: owner 0 goes silent
        req = 2'b11;
        exp_ev(K_GNT, 32'h1, 1); exp_ev(K_GNT, 32'h0, 9);
        exp_ev(K_TMO, 32'h0, 9); exp_ev(K_GNT, 32'h2, 10);
        repeat (10) tick();                       // t0+30
        req = 2'b00; exp_ev(K_GNT, 32'h0, 1);
        tick();                                   // t0+31
        req = 2'b01; exp_ev(K_GNT, 32'h1, 1);
        tick();                                   // t0+32
        wt_data_in[15:0] = 16'h7777; wrt_in = 2'b01; exp_ev(K_WRT, 32'h7777, 0);
        tick();                                   // t0+33: async reset mid-BUSY
        wrt_in = 2'b00; spi_SS_n = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'h0);
        chk("async_rst_ss_n", 32'(SS_n_out), 32'h3);
        tick();                                   // t0+34
        rst = 1'b0; spi_SS_n = 1'b1; req = 2'b11; exp_ev(K_GNT, 32'h1, 1);
        tick();                                   // t0+35
        req = 2'b00; exp_ev(K_GNT, 32'h0, 1);
        repeat (4) tick();

        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL missing_events: got %0d outstanding, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
